// File: rtl/bit4_rca_pkg.sv
// Shared constants for the ripple-carry adder leaf.
package bit4_rca_pkg;

  localparam int RCA_WIDTH = 4;

endpackage

// File: rtl/bit4_rca_full_adder.sv
// Single-bit full adder; stages are chained through their carries by bit4_rca.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit4_rca.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one cycle after in_valid.
module bit4_rca
  import bit4_rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  // Result holds across idle cycles; only the valid flag drops.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum_comb;
      cout_d  = carry[WIDTH];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bit4_rca.sv
// Directed table, exhaustive sweep with mid-sweep reset, and random traffic for bit4_rca.
module tb_bit4_rca;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;

  int checks = 0;
  int failures = 0;

  // Reference state: what the outputs must show after the last edge.
  int m_sum = 0;
  int m_cout = 0;
  int m_valid = 0;
  bit m_known = 1'b0;

  typedef struct {
    logic         r;
    logic         iv;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    int           e_sum;
    int           e_cout;
    int           e_valid;
  } vec_t;

  vec_t tbl[$];

  bit4_rca #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_sum"}, int'(sum), m_sum);
    chk({tag, "_cout"}, int'(cout), m_cout);
    chk({tag, "_valid"}, int'(out_valid), m_valid);
  endtask

  // Called at a negedge: drive, confirm outputs did not follow the inputs,
  // take the edge, advance the model, check at the next negedge.
  task automatic cyc(input logic r, input logic iv, input logic [W-1:0] ai,
                     input logic [W-1:0] bi, input logic ci, input string tag);
    int tot;
    rst = r; in_valid = iv; a = ai; b = bi; cin = ci;
    #1;
    if (m_known) chk_model({tag, "_nocomb"});
    @(posedge clk);
    if (r) begin
      m_sum = 0; m_cout = 0; m_valid = 0; m_known = 1'b1;
    end else if (iv) begin
      tot = int'(ai) + int'(bi) + int'(ci);
      m_sum = tot % (1 << W);
      m_cout = tot / (1 << W);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    @(negedge clk);
    chk_model(tag);
  endtask

  initial begin
    tbl.push_back('{1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 0,    0, 0});
    tbl.push_back('{1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 0,    0, 0});
    tbl.push_back('{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 0,    0, 1});
    tbl.push_back('{1'b0, 1'b1, 4'h2, 4'h1, 1'b0, 3,    0, 1});
    tbl.push_back('{1'b0, 1'b1, 4'h2, 4'h1, 1'b1, 4,    0, 1});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 14,   1, 1});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 15,   1, 1});
    tbl.push_back('{1'b0, 1'b0, 4'h3, 4'h3, 1'b0, 15,   1, 0});
    tbl.push_back('{1'b0, 1'b1, 4'h5, 4'hA, 1'b0, 15,   0, 1});
    tbl.push_back('{1'b0, 1'b0, 4'h1, 4'hA, 1'b0, 15,   0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 15,   0, 0});
    tbl.push_back('{1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 0,    1, 1});
    tbl.push_back('{1'b1, 1'b0, 4'h8, 4'h8, 1'b0, 0,    0, 0});

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].va, tbl[i].vb, tbl[i].vc, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_sum_exp", i), int'(sum), tbl[i].e_sum);
      chk($sformatf("tbl%0d_cout_exp", i), int'(cout), tbl[i].e_cout);
      chk($sformatf("tbl%0d_valid_exp", i), int'(out_valid), tbl[i].e_valid);
    end

    // Exhaustive sweep, with reset forced in the middle.
    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      v = k[8:0];
      if (k == 200) begin
        cyc(1'b1, 1'b1, v[7:4], v[3:0], v[8], "sweep_rst");
        chk("sweep_rst_sum_zero", int'(sum), 0);
        chk("sweep_rst_cout_zero", int'(cout), 0);
      end
      cyc(1'b0, 1'b1, v[7:4], v[3:0], v[8], $sformatf("sweep%0d", k));
    end

    // Random traffic with occasional resets and idle cycles.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
